fetch_queue: RTL and testbench

Parametrised instruction fetch unit with a decoupling instruction queue. Holds the fetch PC, issues one-outstanding requests to instruction memory over a req/ack handshake, and buffers returned instructions with their PC and next PC in a DEPTH-entry FIFO. Decode consumes entries over a valid/ready handshake. A taken branch redirects the PC, flushes the queue and discards any in-flight response. Sits between instruction memory and decode.

---
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch unit: one-outstanding imem request engine feeding a DEPTH-entry
// decoupling queue of {instr, pc}; a taken branch redirects, flushes and drops in-flight data.
module fetch_queue #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 16,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable_fetch,
   input  logic               br_taken,
   input  logic [ADDR_W-1:0]  taddr,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               dec_valid,
   input  logic               dec_ready,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [ADDR_W-1:0]  dec_pc,
   output logic [ADDR_W-1:0]  dec_npc,
   output logic [ADDR_W-1:0]  pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t              state, state_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic [PW-1:0]       rd_ptr, wr_ptr;
   logic [INSTR_W-1:0]  instr_mem [DEPTH];
   logic [ADDR_W-1:0]   pc_mem    [DEPTH];
   logic                ack, push, pop, pending, issue;
   logic                req_n;
   logic [ADDR_W-1:0]   addr_n, pc_n;

   assign dec_valid = (cnt != '0);
   assign dec_instr = instr_mem[rd_ptr];
   assign dec_pc    = pc_mem[rd_ptr];
   assign dec_npc   = dec_pc + ADDR_W'(1);

   always_comb begin
      ack  = imem_req && imem_ack;
      push = (state == REQ) && ack && !br_taken;
      pop  = dec_valid && dec_ready && !br_taken;
      if (br_taken)
         cnt_n = '0;
      else
         cnt_n = cnt + CW'(push) - CW'(pop);

      // A request still in flight next cycle blocks issue; this keeps a free slot for every ack.
      pending = (state != IDLE) && !ack;
      issue   = enable_fetch && !br_taken && (cnt_n < CW'(DEPTH)) && !pending;

      pc_n = pc;
      if (br_taken)
         pc_n = taddr;
      else if (push)
         pc_n = imem_addr + ADDR_W'(1);

      state_n = state;
      req_n   = imem_req;
      addr_n  = imem_addr;
      case (state)
         IDLE: begin
            if (issue) begin
               state_n = REQ;
               req_n   = 1'b1;
               addr_n  = pc_n;
            end
         end
         REQ, DROP: begin
            if (ack) begin
               if (issue) begin
                  state_n = REQ;
                  addr_n  = pc_n;
               end else begin
                  state_n = IDLE;
                  req_n   = 1'b0;
               end
            end else if (br_taken) begin
               state_n = DROP;
            end
         end
         default: begin
            state_n = IDLE;
            req_n   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         pc        <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         pc        <= pc_n;
         imem_req  <= req_n;
         imem_addr <= addr_n;
         if (br_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PW'(1);
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // Queue payload carries no reset; validity comes from cnt alone.
   always_ff @(posedge clock) begin
      if (push) begin
         instr_mem[wr_ptr] <= imem_rdata;
         pc_mem[wr_ptr]    <= imem_addr;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based behavioural model checked every cycle, directed
// scenarios with literal expectations, then a randomized run.
module tb_fetch_queue;

   localparam int          DEPTH  = 4;
   localparam logic [15:0] RST_PC = 16'h0100;

   logic        clock = 1'b0;
   logic        reset, enable_fetch, br_taken, imem_ack, dec_ready;
   logic [15:0] taddr, imem_addr, imem_rdata, dec_instr, dec_pc, dec_npc, pc;
   logic        imem_req, dec_valid;

   int checks = 0;
   int passes = 0;
   bit chk_en = 0;

   fetch_queue #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clock(clock), .reset(reset), .enable_fetch(enable_fetch), .br_taken(br_taken),
      .taddr(taddr), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_npc(dec_npc), .pc(pc)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp)
         passes++;
      else
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference: a list of {instr, pc} entries plus the single outstanding request.
   logic [31:0] mq[$];
   bit          m_req, m_drop;
   logic [15:0] m_addr, m_pc;
   bit          a_ack, a_pop, a_push, a_remain;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_req  = 0;
         m_drop = 0;
         m_addr = RST_PC;
         m_pc   = RST_PC;
      end else begin
         a_ack    = imem_ack && m_req;
         a_pop    = (mq.size() != 0) && dec_ready && !br_taken;
         a_push   = a_ack && !m_drop && !br_taken;
         a_remain = m_req && !a_ack;
         if (br_taken)
            mq.delete();
         else begin
            if (a_pop) void'(mq.pop_front());
            if (a_push) mq.push_back({mem_word(m_addr), m_addr});
         end
         if (br_taken)    m_pc = taddr;
         else if (a_push) m_pc = m_addr + 16'd1;
         if (a_remain)
            m_drop = m_drop || br_taken;
         else if (enable_fetch && !br_taken && mq.size() < DEPTH) begin
            m_req  = 1;
            m_drop = 0;
            m_addr = m_pc;
         end else begin
            m_req  = 0;
            m_drop = 0;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("imem_req", {31'd0, imem_req}, {31'd0, m_req});
         check("imem_addr", {16'd0, imem_addr}, {16'd0, m_addr});
         check("pc", {16'd0, pc}, {16'd0, m_pc});
         check("dec_valid", {31'd0, dec_valid}, {31'd0, mq.size() != 0});
         if (mq.size() != 0) begin
            check("dec_instr", {16'd0, dec_instr}, {16'd0, mq[0][31:16]});
            check("dec_pc", {16'd0, dec_pc}, {16'd0, mq[0][15:0]});
            check("dec_npc", {16'd0, dec_npc}, {16'd0, mq[0][15:0] + 16'd1});
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         @(negedge clock);
         #2;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
   endtask

   initial begin
      bit found;
      reset = 1'b1; enable_fetch = 0; br_taken = 0; imem_ack = 0; dec_ready = 0; taddr = '0;
      #1;
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, dec_valid}, 32'd0);
      check("rst_pc", {16'd0, pc}, {16'd0, RST_PC});
      check("rst_addr", {16'd0, imem_addr}, {16'd0, RST_PC});
      @(negedge clock); #2;
      chk_en = 1;
      step(1);
      reset = 1'b0;

      // Zero-wait streaming
      enable_fetch = 1; imem_ack = 1; dec_ready = 1;
      step(1);
      check("s_req", {31'd0, imem_req}, 32'd1);
      check("s_addr0", {16'd0, imem_addr}, 32'h0100);
      check("s_valid0", {31'd0, dec_valid}, 32'd0);
      step(1);
      check("s_pc0", {16'd0, dec_pc}, 32'h0100);
      check("s_npc0", {16'd0, dec_npc}, 32'h0101);
      check("s_instr0", {16'd0, dec_instr}, {16'd0, mem_word(16'h0100)});
      step(1);
      check("s_pc1", {16'd0, dec_pc}, 32'h0101);
      step(1);
      check("s_pc2", {16'd0, dec_pc}, 32'h0102);

      // Backpressure: queue fills to DEPTH and fetch stops
      dec_ready = 0;
      step(8);
      check("f_req_off", {31'd0, imem_req}, 32'd0);
      check("f_model_full", mq.size(), DEPTH);
      check("f_head", {16'd0, dec_pc}, 32'h0102);
      dec_ready = 1;
      step(1);
      check("f_head_next", {16'd0, dec_pc}, 32'h0103);
      step(10);

      // Delayed ack with redirect during the wait
      do_reset();
      imem_ack = 0; dec_ready = 1; enable_fetch = 1;
      step(1);
      check("d_req", {31'd0, imem_req}, 32'd1);
      step(1);
      check("d_hold1", {16'd0, imem_addr}, 32'h0100);
      br_taken = 1; taddr = 16'h2000;
      step(1);
      br_taken = 0;
      check("d_hold2", {16'd0, imem_addr}, 32'h0100);
      check("d_req2", {31'd0, imem_req}, 32'd1);
      check("d_pc", {16'd0, pc}, 32'h2000);
      step(1);
      check("d_hold3", {16'd0, imem_addr}, 32'h0100);
      imem_ack = 1;
      step(1);
      imem_ack = 0;
      check("d_dropped", {31'd0, dec_valid}, 32'd0);
      found = 0;
      for (int i = 0; i < 4 && !found; i++) begin
         if (imem_req && imem_addr == 16'h2000) found = 1;
         else step(1);
      end
      check("d_refetch", {31'd0, found}, 32'd1);
      imem_ack = 1;
      step(1);
      check("d_first", {16'd0, dec_pc}, 32'h2000);

      // Redirect on the same edge as ack and pop, two entries queued
      do_reset();
      enable_fetch = 1; imem_ack = 1; dec_ready = 0;
      step(3);
      check("b_two", {16'd0, dec_pc}, 32'h0100);
      check("b_model_two", mq.size(), 2);
      br_taken = 1; taddr = 16'h3000; dec_ready = 1;
      step(1);
      br_taken = 0;
      check("b_empty", {31'd0, dec_valid}, 32'd0);
      check("b_pc", {16'd0, pc}, 32'h3000);
      check("b_req", {31'd0, imem_req}, 32'd0);
      step(1);
      check("b_addr", {16'd0, imem_addr}, 32'h3000);

      // PC wrap
      br_taken = 1; taddr = 16'hFFFF;
      step(1);
      br_taken = 0;
      step(2);
      check("w_pc", {16'd0, dec_pc}, 32'hFFFF);
      check("w_npc", {16'd0, dec_npc}, 32'h0000);
      step(1);
      check("w_next", {16'd0, dec_pc}, 32'h0000);

      // Asynchronous reset mid-request
      do_reset();
      enable_fetch = 1; imem_ack = 1; dec_ready = 0;
      step(4);
      imem_ack = 0;
      step(1);
      check("r_req_before", {31'd0, imem_req}, 32'd1);
      check("r_model_three", mq.size(), 3);
      reset = 1;
      #1;
      check("r_req", {31'd0, imem_req}, 32'd0);
      check("r_valid", {31'd0, dec_valid}, 32'd0);
      check("r_pc", {16'd0, pc}, {16'd0, RST_PC});
      step(1);
      reset = 0;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         enable_fetch = ($urandom_range(0, 7) != 0);
         br_taken     = ($urandom_range(0, 15) == 0);
         taddr        = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
         imem_ack     = $urandom_range(0, 1);
         dec_ready    = (i % 200 < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
         step(1);
      end

      chk_en = 0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
